// File: rtl/my_name_sequence_detector_pkg.sv
// Shared state encoding and pattern characters for the "VIKHYATH" detector.
// No logic lives here; the detector imports these names.
package my_name_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      S_V,
      S_VI,
      S_VIK,
      S_VIKH,
      S_VIKHY,
      S_VIKHYA,
      S_VIKHYAT,
      FOUND
   } state_e;

   localparam logic [7:0] CH_V = 8'h56;
   localparam logic [7:0] CH_I = 8'h49;
   localparam logic [7:0] CH_K = 8'h4B;
   localparam logic [7:0] CH_H = 8'h48;
   localparam logic [7:0] CH_Y = 8'h59;
   localparam logic [7:0] CH_A = 8'h41;
   localparam logic [7:0] CH_T = 8'h54;

endpackage

// File: rtl/my_name_sequence_detector_if.sv
// Character stream and detect flag bundled for benches and future wrappers.
// master drives characters, slave consumes them and returns the detect flag.
interface my_name_sequence_detector_if;

   logic [7:0] char;
   logic       eureka;

   modport master (output char, input  eureka);
   modport slave  (input  char, output eureka);

endinterface

// File: rtl/my_name_sequence_detector_ascii_upcase.sv
// Combinational ASCII fold: 'a'..'z' map to 'A'..'Z', everything else passes.
// Zero latency, no state, no flow control.
module ascii_upcase (
   input  logic [7:0] char_i,
   output logic [7:0] char_o
);

   localparam logic [7:0] LC_A = 8'h61;
   localparam logic [7:0] LC_Z = 8'h7A;
   localparam logic [7:0] CASE_BIT = 8'h20;

   always_comb begin
      char_o = char_i;
      if (char_i >= LC_A && char_i <= LC_Z) begin
         char_o = char_i & ~CASE_BIT;
      end
   end

endmodule

// File: rtl/my_name_sequence_detector.sv
// Moore detector for "VIKHYATH"; eureka is a decode of the state register only.
// One character per clk edge, pulse on the edge that samples the final 'H'; CASE_FOLD_EN folds lowercase.
module my_name_sequence_detector
   import my_name_seq_pkg::*;
(
   output logic       eureka,
   input  logic [7:0] char,
   input  logic       clk,
   input  logic       rst
);

   state_e     state_q;
   state_e     state_d;
   logic [7:0] char_cmp;

`ifdef CASE_FOLD_EN
   ascii_upcase u_upcase (
      .char_i (char),
      .char_o (char_cmp)
   );
`else
   assign char_cmp = char;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // 'V' appears only at the head of the pattern, so every mismatch restarts at S_V or IDLE.
   always_comb begin
      state_d = (char_cmp == CH_V) ? S_V : IDLE;
      case (state_q)
         S_V:       if (char_cmp == CH_I) state_d = S_VI;
         S_VI:      if (char_cmp == CH_K) state_d = S_VIK;
         S_VIK:     if (char_cmp == CH_H) state_d = S_VIKH;
         S_VIKH:    if (char_cmp == CH_Y) state_d = S_VIKHY;
         S_VIKHY:   if (char_cmp == CH_A) state_d = S_VIKHYA;
         S_VIKHYA:  if (char_cmp == CH_T) state_d = S_VIKHYAT;
         S_VIKHYAT: if (char_cmp == CH_H) state_d = FOUND;
         default:   ;
      endcase
   end

   assign eureka = (state_q == FOUND);

endmodule

// File: tb/tb_my_name_sequence_detector.sv
// Directed and random character streams checked against a sliding-window model of the pattern.
module tb_my_name_sequence_detector;

   logic clk;
   logic rst;
   my_name_sequence_detector_if bus ();

   my_name_sequence_detector dut (
      .eureka (bus.eureka),
      .char   (bus.char),
      .clk    (clk),
      .rst    (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   int         pulses = 0;
   int         pulse_cyc[$];
   logic [7:0] hist[$];
   string      pat = "VIKHYATH";

   function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CASE_FOLD_EN
      if (c >= 8'h61 && c <= 8'h7A) return c - 8'd32;
`endif
      return c;
   endfunction

   // Detection means the last eight characters since reset spell the pattern.
   function automatic logic model_hit();
      if (hist.size() < 8) return 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (hist[hist.size() - 8 + i] != pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] c, input string tag);
      bus.char = c;
      @(posedge clk);
      #1;
      cyc++;
      hist.push_back(fold(c));
      if (hist.size() > 8) void'(hist.pop_front());
      check_bit(tag, bus.eureka, model_hit());
      if (bus.eureka === 1'b1) begin
         pulses++;
         pulse_cyc.push_back(cyc);
      end
   endtask

   task automatic send_str(input string s, input string tag);
      for (int i = 0; i < s.len(); i++) send(s[i], tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.char = "H";
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      hist.delete();
      check_bit({tag, "_eureka"}, bus.eureka, 1'b0);
      check_bit({tag, "_idle"}, dut.state_q == my_name_seq_pkg::IDLE, 1'b1);
   endtask

   initial begin
      logic [7:0] c;
      string      s;
      int         r;

      rst = 1'b0;
      bus.char = 8'h00;
      @(posedge clk);
      #1;
      do_reset("reset");

      // Near-misses then one real match.
      pulses = 0;
      send_str("VIKVYMVVVIKHYATH", "stream");
      check_int("stream_pulses", pulses, 1);
      check_bit("stream_last", bus.eureka, 1'b1);
      send(8'h00, "stream_fall");
      check_bit("stream_fall_lvl", bus.eureka, 1'b0);

      // Back-to-back matches.
      do_reset("rst_b2b");
      pulses = 0;
      pulse_cyc.delete();
      send_str("VIKHYATHVIKHYATH", "b2b");
      check_int("b2b_pulses", pulses, 2);
      if (pulse_cyc.size() == 2) check_int("b2b_gap", pulse_cyc[1] - pulse_cyc[0], 8);
      else check_int("b2b_gap_count", pulse_cyc.size(), 2);

      // Reset discards partial progress.
      do_reset("rst_mid_pre");
      pulses = 0;
      send_str("VIKHYAT", "mid");
      do_reset("rst_mid");
      send("H", "mid_h");
      check_int("mid_pulses", pulses, 0);

      // Restart from S_VIKHYA on 'V'.
      do_reset("rst_restart");
      pulses = 0;
      send_str("VIKHYAVIKHYATH", "restart");
      check_int("restart_pulses", pulses, 1);
      check_bit("restart_last", bus.eureka, 1'b1);

      // Bad char and NUL return to IDLE.
      do_reset("rst_bad");
      pulses = 0;
      send_str("VIKHYATX", "bad");
      send(8'h00, "bad_nul");
      check_int("bad_pulses", pulses, 0);
      check_bit("bad_idle", dut.state_q == my_name_seq_pkg::IDLE, 1'b1);

      // Lowercase handling depends on folding.
      do_reset("rst_lower");
      pulses = 0;
      send_str("vikhyath", "lower");
      send_str("ViKhYaTh", "mixed");
`ifdef CASE_FOLD_EN
      check_int("lower_pulses", pulses, 2);
`else
      check_int("lower_pulses", pulses, 0);
`endif

      // Random traffic, biased towards pattern letters and whole-pattern bursts.
      do_reset("rst_rand");
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_reset("rand_rst");
         end else if (r < 8) begin
            s = ($urandom_range(0, 1) == 0) ? "VIKHYATH" : "vikhYATH";
            send_str(s, "rand_burst");
         end else if (r < 75) begin
            c = pat[$urandom_range(0, 7)];
            if ($urandom_range(0, 4) == 0) c = c | 8'h20;
            send(c, "rand_letter");
         end else begin
            c = 8'($urandom_range(0, 255));
            send(c, "rand_byte");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
